// File: rtl/mult_byte_sequencer.sv
// -----------------------------------------------------------------------------
// mult_byte_sequencer
//
// Operand loader and result serializer for a combinational WIDTHxWIDTH
// multiplier on a pin-limited tile. Operand A and then operand B arrive as
// bytes on din (valid/ready). They are presented on registered op_a/op_b.
// After SETTLE_CYCLES cycles the product is captured. It is then returned as
// two bytes on dout (valid/ready). dout_last marks the second byte.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         operand byte in
//   din_valid   din holds a byte
//   din_ready   block accepts a byte this cycle (registered)
//   op_a, op_b  registered operands driven to the multiplier
//   prod        multiplier result, combinational from op_a/op_b
//   dout        result byte out (registered)
//   dout_valid  dout holds a result byte (registered)
//   dout_ready  consumer accepts dout this cycle
//   dout_last   current dout is the final result byte (registered)
//   busy        high in every state except LOAD_A (registered)
// -----------------------------------------------------------------------------
module mult_byte_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter bit LSB_FIRST     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy
);

    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        SETTLE = 3'd2,
        SEND_0 = 3'd3,
        SEND_1 = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [WIDTH-1:0]       op_a_r, op_a_s;
    logic [WIDTH-1:0]       op_b_r, op_b_s;
    logic [2*WIDTH-1:0]     result_r, result_s;
    logic [WIDTH-1:0]       dout_r, dout_s;
    logic                   dout_valid_r, dout_valid_s;
    logic                   dout_last_r, dout_last_s;
    logic                   din_ready_r, din_ready_s;
    logic                   busy_r, busy_s;
    logic                   din_xfer_s;
    logic                   dout_xfer_s;

    // Byte sent first, selected by the configured byte order.
    function automatic logic [WIDTH-1:0] first_byte(input logic [2*WIDTH-1:0] p);
        if (LSB_FIRST) begin
            return p[WIDTH-1:0];
        end else begin
            return p[2*WIDTH-1:WIDTH];
        end
    endfunction

    // Byte sent second: the other half of the product.
    function automatic logic [WIDTH-1:0] second_byte(input logic [2*WIDTH-1:0] p);
        if (LSB_FIRST) begin
            return p[2*WIDTH-1:WIDTH];
        end else begin
            return p[WIDTH-1:0];
        end
    endfunction

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        op_a_s       = op_a_r;
        op_b_s       = op_b_r;
        result_s     = result_r;
        dout_s       = dout_r;
        dout_valid_s = dout_valid_r;
        dout_last_s  = dout_last_r;
        // Transfers use the registered ready/valid that the other side sees.
        din_xfer_s   = din_valid & din_ready_r;
        dout_xfer_s  = dout_ready & dout_valid_r;

        case (state_r)
            LOAD_A: begin
                if (din_xfer_s) begin
                    op_a_s  = din;
                    state_s = LOAD_B;
                end else begin
                    state_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (din_xfer_s) begin
                    op_b_s  = din;
                    cnt_s   = SETTLE_LOAD;
                    state_s = SETTLE;
                end else begin
                    state_s = LOAD_B;
                end
            end
            SETTLE: begin
                // The counter is loaded with SETTLE_CYCLES-1, so this state
                // lasts exactly SETTLE_CYCLES cycles.
                if (cnt_r == CNT_ZERO) begin
                    result_s     = prod;
                    dout_s       = first_byte(prod);
                    dout_valid_s = 1'b1;
                    dout_last_s  = 1'b0;
                    state_s      = SEND_0;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            SEND_0: begin
                if (dout_xfer_s) begin
                    dout_s      = second_byte(result_r);
                    dout_last_s = 1'b1;
                    state_s     = SEND_1;
                end else begin
                    state_s = SEND_0;
                end
            end
            SEND_1: begin
                if (dout_xfer_s) begin
                    dout_valid_s = 1'b0;
                    dout_last_s  = 1'b0;
                    state_s      = LOAD_A;
                end else begin
                    state_s = SEND_1;
                end
            end
            default: begin
                // Unreachable encodings recover to an idle, empty output.
                state_s      = LOAD_A;
                dout_valid_s = 1'b0;
                dout_last_s  = 1'b0;
            end
        endcase

        // Ready and busy are registered from the state being entered, so
        // they line up with that state in the next cycle.
        din_ready_s = (state_s == LOAD_A) || (state_s == LOAD_B);
        busy_s      = (state_s != LOAD_A);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOAD_A;
            cnt_r        <= CNT_ZERO;
            op_a_r       <= {WIDTH{1'b0}};
            op_b_r       <= {WIDTH{1'b0}};
            result_r     <= {(2*WIDTH){1'b0}};
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            din_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            op_a_r       <= op_a_s;
            op_b_r       <= op_b_s;
            result_r     <= result_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            dout_last_r  <= dout_last_s;
            din_ready_r  <= din_ready_s;
            busy_r       <= busy_s;
        end
    end

    assign din_ready  = din_ready_r;
    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mult_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_byte_sequencer
//
// Three instances share clk and reset:
//   0: SETTLE_CYCLES=1, LSB_FIRST=1
//   1: SETTLE_CYCLES=1, LSB_FIRST=0
//   2: SETTLE_CYCLES=3, LSB_FIRST=1
// The external multiplier is modelled as op_a*op_b. Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din        [3];
    logic        din_valid  [3];
    logic        din_ready  [3];
    logic [7:0]  op_a       [3];
    logic [7:0]  op_b       [3];
    logic [15:0] prod       [3];
    logic [7:0]  dout       [3];
    logic        dout_valid [3];
    logic        dout_ready [3];
    logic        dout_last  [3];
    logic        busy       [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mult_byte_sequencer #(
            .WIDTH        (8),
            .SETTLE_CYCLES((g == 2) ? 3 : 1),
            .LSB_FIRST    ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .din       (din[g]),
            .din_valid (din_valid[g]),
            .din_ready (din_ready[g]),
            .op_a      (op_a[g]),
            .op_b      (op_b[g]),
            .prod      (prod[g]),
            .dout      (dout[g]),
            .dout_valid(dout_valid[g]),
            .dout_ready(dout_ready[g]),
            .dout_last (dout_last[g]),
            .busy      (busy[g])
        );
        assign prod[g] = 16'(op_a[g]) * 16'(op_b[g]);
    end

    function automatic int sc(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit lsb(input int k);
        return (k != 1);
    endfunction

    // Reference: the unsigned product split into bytes in the configured order.
    task automatic model(input int k, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] e1, output logic [7:0] e2);
        int p;
        p = int'(a) * int'(b);
        if (lsb(k)) begin
            e1 = p[7:0];
            e2 = p[15:8];
        end else begin
            e1 = p[15:8];
            e2 = p[7:0];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm, input int k);
        chk({nm, "_dout_valid"}, dout_valid[k], 1'b0);
        chk({nm, "_dout_last"},  dout_last[k],  1'b0);
        chk({nm, "_dout"},       dout[k],       8'h00);
        chk({nm, "_op_a"},       op_a[k],       8'h00);
        chk({nm, "_op_b"},       op_b[k],       8'h00);
        chk({nm, "_busy"},       busy[k],       1'b0);
        chk({nm, "_din_ready"},  din_ready[k],  1'b0);
    endtask

    // One complete transaction with optional output stall and optional
    // junk 0xAA held on din after operand B.
    task automatic do_txn(input int k, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input bit hold,
                          input logic [7:0] e1, input logic [7:0] e2);
        int n;
        @(negedge clk);
        din[k] = a;
        din_valid[k] = 1'b1;
        n = 0;
        while (!din_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", (n < 50), 1'b1);
        @(negedge clk);
        chk("busy_after_a", busy[k], 1'b1);
        chk("ready_load_b", din_ready[k], 1'b1);
        din[k] = b;
        @(negedge clk);
        if (hold) begin
            din[k] = 8'hAA;
        end else begin
            din_valid[k] = 1'b0;
        end
        n = 0;
        while (!dout_valid[k] && n < 50) begin
            chk("ready_settle", din_ready[k], 1'b0);
            chk("busy_settle", busy[k], 1'b1);
            @(negedge clk);
            n++;
        end
        chk("latency", n, sc(k));
        chk("first_byte", dout[k], e1);
        chk("first_last", dout_last[k], 1'b0);
        for (int i = 0; i < stall; i++) begin
            dout_ready[k] = 1'b0;
            @(negedge clk);
            chk("stall_byte", dout[k], e1);
            chk("stall_valid", dout_valid[k], 1'b1);
            chk("stall_last", dout_last[k], 1'b0);
            chk("stall_ready", din_ready[k], 1'b0);
        end
        dout_ready[k] = 1'b1;
        @(negedge clk);
        chk("second_byte", dout[k], e2);
        chk("second_last", dout_last[k], 1'b1);
        chk("second_valid", dout_valid[k], 1'b1);
        chk("busy_send1", busy[k], 1'b1);
        chk("ready_send1", din_ready[k], 1'b0);
        @(negedge clk);
        dout_ready[k] = 1'b0;
        din_valid[k]  = 1'b0;
        chk("end_valid", dout_valid[k], 1'b0);
        chk("end_last", dout_last[k], 1'b0);
        chk("end_busy", busy[k], 1'b0);
        chk("end_ready", din_ready[k], 1'b1);
        chk("hold_op_a", op_a[k], a);
        chk("hold_op_b", op_b[k], b);
    endtask

    // Three back-to-back transactions with din_valid and dout_ready high.
    task automatic b2b(input int k);
        logic [7:0] ops [6];
        logic [7:0] rx [$];
        logic [7:0] expq [$];
        int         fc [$];
        logic [7:0] e1, e2;
        int         idx;
        bit         pending;
        ops = '{8'h00, 8'h7F, 8'h01, 8'h01, 8'hC8, 8'h64};
        for (int t = 0; t < 3; t++) begin
            model(k, ops[2*t], ops[2*t+1], e1, e2);
            expq.push_back(e1);
            expq.push_back(e2);
        end
        @(negedge clk);
        idx = 0;
        din[k] = ops[0];
        din_valid[k] = 1'b1;
        dout_ready[k] = 1'b1;
        pending = din_ready[k];
        for (int c = 0; c < 200 && rx.size() < 6; c++) begin
            @(negedge clk);
            if (pending) begin
                idx++;
                if (idx < 6) begin
                    din[k] = ops[idx];
                end else begin
                    din_valid[k] = 1'b0;
                end
            end
            pending = din_valid[k] && din_ready[k];
            if (dout_valid[k]) begin
                rx.push_back(dout[k]);
                if (!dout_last[k]) fc.push_back(cyc);
            end
        end
        @(negedge clk);
        dout_ready[k] = 1'b0;
        din_valid[k]  = 1'b0;
        chk("b2b_count", rx.size(), 6);
        chk("b2b_firsts", fc.size(), 3);
        for (int i = 0; i < rx.size() && i < 6; i++) chk("b2b_byte", rx[i], expq[i]);
        for (int i = 0; i + 1 < fc.size(); i++) chk("b2b_spacing", fc[i+1] - fc[i], 4 + sc(k));
    endtask

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        bit         hold;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int         n;
        int         k;
        logic [7:0] a, b, e1, e2;

        vecs[0] = '{0, 8'h0F, 8'h11, 0, 1'b0, 8'hFF, 8'h00};
        vecs[1] = '{0, 8'hFF, 8'hFF, 5, 1'b0, 8'h01, 8'hFE};
        vecs[2] = '{1, 8'hFF, 8'hFF, 5, 1'b0, 8'hFE, 8'h01};
        vecs[3] = '{0, 8'h03, 8'h05, 0, 1'b1, 8'h0F, 8'h00};
        vecs[4] = '{0, 8'h80, 8'h02, 2, 1'b0, 8'h00, 8'h01};
        vecs[5] = '{1, 8'hC8, 8'h64, 1, 1'b1, 8'h4E, 8'h20};
        vecs[6] = '{2, 8'hC8, 8'h64, 3, 1'b0, 8'h20, 8'h4E};
        vecs[7] = '{2, 8'h00, 8'hFF, 0, 1'b1, 8'h00, 8'h00};
        vecs[8] = '{1, 8'h01, 8'h01, 0, 1'b0, 8'h00, 8'h01};

        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            din_valid[i] = 1'b0;
            dout_ready[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) chk_idle("reset", i);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_ready_up", din_ready[i], 1'b1);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].hold,
                   vecs[i].e1, vecs[i].e2);
        end

        // Reset during SEND_1 of 0x80*0x02 on instance 0.
        @(negedge clk);
        din[0] = 8'h80;
        din_valid[0] = 1'b1;
        n = 0;
        while (!din_ready[0] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        din[0] = 8'h02;
        @(negedge clk);
        din_valid[0] = 1'b0;
        n = 0;
        while (!dout_valid[0] && n < 50) begin @(negedge clk); n++; end
        chk("mid_first", dout[0], 8'h00);
        dout_ready[0] = 1'b1;
        @(negedge clk);
        chk("mid_in_send1", dout_last[0], 1'b1);
        chk("mid_second", dout[0], 8'h01);
        dout_ready[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("mid_reset", 0);
        @(negedge clk);
        chk("mid_reset_ready", din_ready[0], 1'b1);
        chk("mid_reset_novalid", dout_valid[0], 1'b0);
        do_txn(0, 8'h02, 8'h03, 0, 1'b0, 8'h06, 8'h00);

        b2b(0);
        b2b(2);
        b2b(1);

        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(0, 2);
            a = 8'($urandom);
            b = 8'($urandom);
            model(k, a, b, e1, e2);
            do_txn(k, a, b, $urandom_range(0, 4), 1'($urandom_range(0, 1)), e1, e2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
